ga_sync_irq: RTL and testbench

Gate Array sync and raster-interrupt stage, directly downstream of the CRTC (UM6845R) in the Amstrad CPC core. Consumes raw CRTC HSYNC/VSYNC on the character-clock enable and produces the monitor HSYNC/VSYNC, the Z80 raster interrupt (52-line counter with VSYNC resynchronisation) and the HSYNC-synchronised screen mode. Sits between the CRTC and the video serializer/CPU interrupt logic.

---
 rtl/ga_pkg.sv | 35 +++
 rtl/ga_irq.sv | 95 +++++++++
 rtl/ga_sync_irq.sv | 153 +++++++++++++++
 tb/tb_ga_sync_irq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ga_pkg
//  Description : Shared constants and types for the Gate Array sync and
//                raster-interrupt stage (ga_sync_irq, ga_irq).
//                R52_WRAP      - interrupt line counter period
//                INT_VS_THRESH - counter level at which a VSYNC resync
//                                raises INT
//                HS_DELAY/HS_MAX - HSYNC_OUT start offset / maximum width
//                VS_DELAY/VS_WIDTH - VSYNC_OUT start offset / fixed width
//  Revision    : 1.0 - initial release
// ============================================================================
package ga_pkg;

  localparam int unsigned R52_WRAP      = 52;
  localparam int unsigned INT_VS_THRESH = 32;
  localparam int unsigned HS_DELAY      = 2;
  localparam int unsigned HS_MAX        = 4;
  localparam int unsigned VS_DELAY      = 2;
  localparam int unsigned VS_WIDTH      = 4;

  // Number of HSYNC falls between a VSYNC rise and the counter resync.
  localparam logic [1:0] VDLY_LOAD = 2'd2;

  typedef logic [1:0] ga_mode_t;

  // True when a 3-bit shaper count lies in [lo, lo+width-1].
  function automatic logic in_window(input logic [2:0] cnt,
                                     input int unsigned lo,
                                     input int unsigned width);
    return (32'(cnt) >= lo) && (32'(cnt) < (lo + width));
  endfunction

endpackage : ga_pkg
`default_nettype wire

// File: rtl/ga_irq.sv
`default_nettype none
// ============================================================================
//  Module      : ga_irq
//  Description : 52-line raster interrupt counter with VSYNC resynchronisation.
//                Strobes hs_fall_i / vs_rise_i are already qualified with the
//                character-clock enable; int_ack_i and rmr_clr_i act on any
//                clock edge.
//  Ports       : clk_i      - system clock
//                rst_i      - asynchronous active-high reset
//                hs_fall_i  - CRTC HSYNC falling-edge strobe
//                vs_rise_i  - CRTC VSYNC rising-edge strobe
//                int_ack_i  - Z80 interrupt acknowledge pulse
//                rmr_clr_i  - RMR write with counter-reset bit set
//                int_o      - raster interrupt request (level)
//                r52_o      - interrupt line counter
//  Revision    : 1.0 - initial release
// ============================================================================
module ga_irq
  import ga_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hs_fall_i,
  input  logic       vs_rise_i,
  input  logic       int_ack_i,
  input  logic       rmr_clr_i,
  output logic       int_o,
  output logic [5:0] r52_o
);

  logic [5:0] r52_q, r52_d;
  logic [1:0] vdly_q, vdly_d;
  logic       int_q, int_d;
  logic       w_resync;

  always_comb begin
    r52_d    = r52_q;
    vdly_d   = vdly_q;
    int_d    = int_q;
    w_resync = 1'b0;

    if (rmr_clr_i) begin
      // Software reset of the counter overrides every other event.
      r52_d = '0;
      int_d = 1'b0;
    end else begin
      if (vs_rise_i) begin
        vdly_d = VDLY_LOAD;
      end else if (hs_fall_i && (vdly_q != 2'd0)) begin
        vdly_d   = vdly_q - 2'd1;
        w_resync = (vdly_q == 2'd1);
      end

      // Acknowledge is applied first so that an interrupt raised on the
      // same edge below takes precedence over the clear.
      if (int_ack_i) begin
        int_d    = 1'b0;
        r52_d[5] = 1'b0;
      end

      if (w_resync) begin
        if (r52_q >= 6'(INT_VS_THRESH)) begin
          int_d = 1'b1;
        end
        r52_d = '0;
      end else if (hs_fall_i) begin
        // Wrap is judged on the pre-acknowledge value so an ack arriving
        // with the 52nd fall cannot skip the interrupt.
        if (r52_q == 6'(R52_WRAP - 1)) begin
          r52_d = '0;
          int_d = 1'b1;
        end else begin
          r52_d = r52_d + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r52_q  <= '0;
      vdly_q <= '0;
      int_q  <= 1'b0;
    end else begin
      r52_q  <= r52_d;
      vdly_q <= vdly_d;
      int_q  <= int_d;
    end
  end

  assign int_o = int_q;
  assign r52_o = r52_q;

endmodule : ga_irq
`default_nettype wire

// File: rtl/ga_sync_irq.sv
`default_nettype none
// ============================================================================
//  Module      : ga_sync_irq
//  Description : Gate Array sync and raster-interrupt stage. Shapes the raw
//                CRTC HSYNC/VSYNC into monitor syncs, drives the Z80 raster
//                interrupt and latches the screen mode on HSYNC_OUT rise.
//                Optional build macro: GA_CSYNC_EN (registered composite
//                sync on CSYNC; when undefined CSYNC is tied low).
//  Ports       : CLOCK      - system clock
//                RESET      - asynchronous active-high reset
//                CLKEN      - character-clock enable
//                CRTC_HSYNC - raw CRTC HSYNC
//                CRTC_VSYNC - raw CRTC VSYNC
//                INT_ACK    - Z80 interrupt acknowledge pulse
//                RMR_WR     - RMR write strobe
//                RMR_DATA   - [1:0] screen mode, [4] interrupt counter reset
//                INT        - raster interrupt request
//                HSYNC_OUT  - monitor HSYNC
//                VSYNC_OUT  - monitor VSYNC
//                MODE       - active screen mode
//                CSYNC      - composite sync
//                R52        - interrupt line counter (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module ga_sync_irq
  import ga_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic       CRTC_HSYNC,
  input  logic       CRTC_VSYNC,
  input  logic       INT_ACK,
  input  logic       RMR_WR,
  input  logic [4:0] RMR_DATA,
  output logic       INT,
  output logic       HSYNC_OUT,
  output logic       VSYNC_OUT,
  output ga_mode_t   MODE,
  output logic       CSYNC,
  output logic [5:0] R52
);

  localparam logic [2:0] HCNT_SAT = 3'd7;
  localparam logic [2:0] VCNT_SAT = 3'(VS_DELAY + VS_WIDTH);

  logic       hs_q, vs_q;
  logic [2:0] hcnt_q, hcnt_d;
  logic [2:0] vcnt_q, vcnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  ga_mode_t   mode_q, mode_pend_q;

  logic       w_hs_rise, w_hs_fall, w_vs_rise;
  logic       w_hs_fall_en, w_vs_rise_en;
  logic       w_rmr_clr;
  logic       w_rmr_unused;

  // Edges are judged against the previous CLKEN sample.
  assign w_hs_rise    = CRTC_HSYNC & ~hs_q;
  assign w_hs_fall    = ~CRTC_HSYNC & hs_q;
  assign w_vs_rise    = CRTC_VSYNC & ~vs_q;
  assign w_hs_fall_en = CLKEN & w_hs_fall;
  assign w_vs_rise_en = CLKEN & w_vs_rise;
  assign w_rmr_clr    = RMR_WR & RMR_DATA[4];
  assign w_rmr_unused = ^RMR_DATA[3:2];

  // HSYNC shaper: count from the CRTC rise, output within the window.
  // Using the next count makes the output start two characters after the
  // CRTC rise and gives min(width-2, 4) characters.
  always_comb begin
    hcnt_d = hcnt_q;
    if (w_hs_rise) begin
      hcnt_d = '0;
    end else if (CRTC_HSYNC && (hcnt_q != HCNT_SAT)) begin
      hcnt_d = hcnt_q + 3'd1;
    end
    hsync_d = CRTC_HSYNC & in_window(hcnt_d, HS_DELAY, HS_MAX);
  end

  // VSYNC shaper: counts HSYNC falls after the CRTC rise, fixed 4 lines.
  always_comb begin
    vcnt_d = vcnt_q;
    if (w_vs_rise) begin
      vcnt_d = '0;
    end else if (w_hs_fall && (vcnt_q < VCNT_SAT)) begin
      vcnt_d = vcnt_q + 3'd1;
    end
    vsync_d = in_window(vcnt_d, VS_DELAY, VS_WIDTH);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      mode_q      <= '0;
      mode_pend_q <= '0;
    end else begin
      if (RMR_WR) begin
        mode_pend_q <= ga_mode_t'(RMR_DATA[1:0]);
      end
      if (CLKEN) begin
        hs_q    <= CRTC_HSYNC;
        vs_q    <= CRTC_VSYNC;
        hcnt_q  <= hcnt_d;
        vcnt_q  <= vcnt_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        // Old pending mode is transferred when a write coincides.
        if (hsync_d && !hsync_q) begin
          mode_q <= mode_pend_q;
        end
      end
    end
  end

`ifdef GA_CSYNC_EN
  logic csync_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      csync_q <= 1'b0;
    end else if (CLKEN) begin
      csync_q <= hsync_d ^ vsync_d;
    end
  end

  assign CSYNC = csync_q;
`else
  assign CSYNC = 1'b0;
`endif

  ga_irq u_irq (
    .clk_i     (CLOCK),
    .rst_i     (RESET),
    .hs_fall_i (w_hs_fall_en),
    .vs_rise_i (w_vs_rise_en),
    .int_ack_i (INT_ACK),
    .rmr_clr_i (w_rmr_clr),
    .int_o     (INT),
    .r52_o     (R52)
  );

  assign HSYNC_OUT = hsync_q;
  assign VSYNC_OUT = vsync_q;
  assign MODE      = mode_q;

endmodule : ga_sync_irq
`default_nettype wire

// File: tb/tb_ga_sync_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ga_sync_irq
//  Description : Directed self-checking bench for ga_sync_irq. One character
//                is two system clocks: CLKEN high on the first, low on the
//                second. Outputs are sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ga_sync_irq;

  logic       CLOCK      = 1'b0;
  logic       RESET      = 1'b1;
  logic       CLKEN      = 1'b0;
  logic       CRTC_HSYNC = 1'b0;
  logic       CRTC_VSYNC = 1'b0;
  logic       INT_ACK    = 1'b0;
  logic       RMR_WR     = 1'b0;
  logic [4:0] RMR_DATA   = 5'd0;
  logic       INT;
  logic       HSYNC_OUT;
  logic       VSYNC_OUT;
  logic [1:0] MODE;
  logic       CSYNC;
  logic [5:0] R52;

  int   n_cmp  = 0;
  int   n_err  = 0;
  logic vs_lvl = 1'b0;
  int   first_hi;
  int   width_hi;

  ga_sync_irq dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .CLKEN      (CLKEN),
    .CRTC_HSYNC (CRTC_HSYNC),
    .CRTC_VSYNC (CRTC_VSYNC),
    .INT_ACK    (INT_ACK),
    .RMR_WR     (RMR_WR),
    .RMR_DATA   (RMR_DATA),
    .INT        (INT),
    .HSYNC_OUT  (HSYNC_OUT),
    .VSYNC_OUT  (VSYNC_OUT),
    .MODE       (MODE),
    .CSYNC      (CSYNC),
    .R52        (R52)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One character with CLKEN; optional RMR write on the same clock edge.
  task automatic step(input logic hs, input logic wr = 1'b0, input logic [4:0] d = 5'd0);
    @(negedge CLOCK);
    CRTC_HSYNC = hs;
    CRTC_VSYNC = vs_lvl;
    CLKEN      = 1'b1;
    RMR_WR     = wr;
    RMR_DATA   = d;
    @(negedge CLOCK);
    CLKEN      = 1'b0;
    RMR_WR     = 1'b0;
  endtask

  task automatic line(input int w, input int lo);
    repeat (w) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  // Acknowledge on a clock edge where CLKEN is low.
  task automatic ack();
    @(negedge CLOCK);
    INT_ACK = 1'b1;
    @(negedge CLOCK);
    INT_ACK = 1'b0;
  endtask

  task automatic measure(input int w, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int i = 0; i < w + 6; i++) begin
      step(i < w);
      if (HSYNC_OUT === 1'b1) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLOCK);
    chk("rst_int",   INT,       0);
    chk("rst_hs",    HSYNC_OUT, 0);
    chk("rst_vs",    VSYNC_OUT, 0);
    chk("rst_mode",  MODE,      0);
    chk("rst_csync", CSYNC,     0);
    chk("rst_r52",   R52,       0);
    RESET = 1'b0;

    // HSYNC width shaping
    measure(14, first_hi, width_hi);
    chk("hs14_start", first_hi, 2);
    chk("hs14_width", width_hi, 4);
    measure(3, first_hi, width_hi);
    chk("hs3_start", first_hi, 2);
    chk("hs3_width", width_hi, 1);
    measure(2, first_hi, width_hi);
    chk("hs2_width", width_hi, 0);
    chk("r52_after3", R52, 3);

    // Interrupt period: 52nd fall raises INT and wraps
    repeat (48) line(4, 4);
    chk("pre_wrap_r52", R52, 51);
    chk("pre_wrap_int", INT, 0);
    repeat (4) step(1'b1);
    step(1'b0);
    chk("wrap_int", INT, 1);
    chk("wrap_r52", R52, 0);
    repeat (3) step(1'b0);
    ack();
    chk("ack_int", INT, 0);
    chk("ack_r52", R52, 0);

    repeat (51) line(4, 4);
    chk("per2_pre_int", INT, 0);
    chk("per2_pre_r52", R52, 51);
    repeat (4) step(1'b1);
    step(1'b0);
    chk("per2_int", INT, 1);
    chk("per2_r52", R52, 0);
    repeat (3) step(1'b0);
    ack();
    chk("per2_ack_int", INT, 0);

    // Acknowledge clears bit 5
    repeat (40) line(4, 4);
    chk("r52_40", R52, 40);
    ack();
    chk("ack_bit5_r52", R52, 8);
    chk("ack_bit5_int", INT, 0);

    // VSYNC resync with counter high
    repeat (27) line(4, 4);
    chk("r52_35", R52, 35);
    vs_lvl = 1'b1;
    step(1'b0);
    chk("vs_start_vsout", VSYNC_OUT, 0);
    line(4, 1);
    chk("rs_hi_f1_r52", R52, 36);
    chk("rs_hi_f1_int", INT, 0);
    chk("rs_hi_f1_vsout", VSYNC_OUT, 0);
    repeat (3) step(1'b0);
    line(4, 1);
    chk("rs_hi_int", INT, 1);
    chk("rs_hi_r52", R52, 0);
    chk("rs_hi_vsout_f2", VSYNC_OUT, 1);
    repeat (3) step(1'b0);
    vs_lvl = 1'b0;
    repeat (3) line(4, 4);
    chk("rs_hi_vsout_f5", VSYNC_OUT, 1);
    line(4, 4);
    chk("rs_hi_vsout_f6", VSYNC_OUT, 0);
    chk("rs_hi_r52_f6", R52, 4);
    ack();
    chk("rs_hi_ack_int", INT, 0);

    // VSYNC resync with counter low
    repeat (6) line(4, 4);
    chk("r52_10", R52, 10);
    vs_lvl = 1'b1;
    step(1'b0);
    line(4, 4);
    chk("rs_lo_f1_r52", R52, 11);
    line(4, 4);
    chk("rs_lo_r52", R52, 0);
    chk("rs_lo_int", INT, 0);
    vs_lvl = 1'b0;

    // RMR counter reset coinciding with a wrap, then mode transfer
    repeat (51) line(4, 4);
    chk("rmr_pre_r52", R52, 51);
    repeat (4) step(1'b1);
    step(1'b0, 1'b1, 5'h11);
    chk("rmr_r52", R52, 0);
    chk("rmr_int", INT, 0);
    chk("rmr_mode_hold", MODE, 0);
    repeat (3) step(1'b0);
    step(1'b1);
    step(1'b1);
    chk("mode_before_hs", MODE, 0);
    step(1'b1);
    chk("mode_at_hs", MODE, 1);
    chk("hs_at_mode", HSYNC_OUT, 1);
`ifdef GA_CSYNC_EN
    chk("csync_hs", CSYNC, 1);
`else
    chk("csync_hs", CSYNC, 0);
`endif

    // Asynchronous reset mid-pulse
    #2 RESET = 1'b1;
    #1;
    chk("arst_hs", HSYNC_OUT, 0);
    chk("arst_mode", MODE, 0);
    chk("arst_csync", CSYNC, 0);
    RESET = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ga_sync_irq
`default_nettype wire
